dense_layer_mac: RTL and testbench

- Hidden-layer stage sitting directly downstream of the image loader.
- Consumes the 784-pixel stream on x_tdata/x_tvalid/x_tready.
- Performs NUM_NEURONS parallel multiply-accumulates against weights read from an external weight BRAM (1-cycle read latency), then adds a per-neuron bias and applies ReLU.
- Streams the NUM_NEURONS activations out serially to the next layer.

---
 rtl/mnist_nn_pkg.sv | 23 ++
 rtl/mac_lane.sv | 51 +++++
 rtl/dense_layer_mac.sv | 140 ++++++++++++++
 tb/tb_dense_layer_mac.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_nn_pkg.sv
// Shared constants, FSM state type and activation helper for the MNIST network stages.
package mnist_nn_pkg;

  localparam int unsigned N_INPUTS    = 784;
  localparam int unsigned NUM_NEURONS = 16;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned WEIGHT_W    = 8;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned ADDR_W      = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    BIAS   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // ReLU on a w-bit two's complement value carried in the low bits of v.
  function automatic logic [63:0] relu(input logic [63:0] v, input int unsigned w);
    return v[w-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: signed accumulator with load/accumulate and a bias-add + ReLU result register.
module mac_lane #(
  parameter int unsigned PIX_W    = mnist_nn_pkg::PIX_W,
  parameter int unsigned WEIGHT_W = mnist_nn_pkg::WEIGHT_W,
  parameter int unsigned ACC_W    = mnist_nn_pkg::ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       accum,
  input  logic                       bias_add,
  input  logic [PIX_W-1:0]           pix,
  input  logic signed [WEIGHT_W-1:0] weight,
  output logic [ACC_W-1:0]           act
);
  import mnist_nn_pkg::*;

  localparam int unsigned PROD_W = PIX_W + WEIGHT_W + 1;

  logic signed [PIX_W:0]       pix_s;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     prod_ext;
  logic signed [ACC_W-1:0]     bias_ext;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     sum;

  // Unsigned pixel times signed weight, sign-extended (or wrapped) to the accumulator width.
  always_comb begin
    pix_s    = {1'b0, pix};
    prod     = PROD_W'(pix_s) * PROD_W'(weight);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'(weight);
    sum      = acc + bias_ext;
  end

  // Accumulator (first pixel loads) and activation register (bias row adds, then ReLU).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      act <= '0;
    end else begin
      if (load)
        acc <= prod_ext;
      else if (accum)
        acc <= acc + prod_ext;
      if (bias_add)
        act <= ACC_W'(relu(64'(sum), ACC_W));
    end
  end

endmodule

// File: rtl/dense_layer_mac.sv
// Dense hidden layer: streams pixels, MACs NUM_NEURONS lanes against weight BRAM rows,
// adds bias, applies ReLU and streams the activations out serially.
module dense_layer_mac #(
  parameter int unsigned N_INPUTS    = mnist_nn_pkg::N_INPUTS,
  parameter int unsigned NUM_NEURONS = mnist_nn_pkg::NUM_NEURONS,
  parameter int unsigned PIX_W       = mnist_nn_pkg::PIX_W,
  parameter int unsigned WEIGHT_W    = mnist_nn_pkg::WEIGHT_W,
  parameter int unsigned ACC_W       = mnist_nn_pkg::ACC_W,
  parameter int unsigned ADDR_W      = mnist_nn_pkg::ADDR_W
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [31:0]                     x_tdata,
  input  logic                            x_tvalid,
  output logic                            x_tready,
  output logic                            w_en,
  output logic [ADDR_W-1:0]               w_addr,
  input  logic [NUM_NEURONS*WEIGHT_W-1:0] w_rdata,
  output logic [31:0]                     y_tdata,
  output logic                            y_tvalid,
  input  logic                            y_tready,
  output logic                            y_tlast,
  output logic                            busy
);
  import mnist_nn_pkg::*;

  localparam int unsigned       OUT_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_INPUTS - 1);
  localparam logic [ADDR_W-1:0] BIAS_ROW  = ADDR_W'(N_INPUTS);
  localparam logic [OUT_W-1:0]  LAST_WORD = OUT_W'(NUM_NEURONS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] in_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [PIX_W-1:0]  pix_q;
  logic              mac_v;
  logic              first_q;
  logic              bias_v;
  logic              x_hs;
  logic              y_hs;
  logic [ACC_W-1:0]  act [NUM_NEURONS];

  // Only the low PIX_W bits of the loader word carry pixel data.
  logic unused_x_hi;
  assign unused_x_hi = ^x_tdata[31:PIX_W];

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next state, stream ready and weight fetch control.
  always_comb begin
    state_nxt = state;
    x_tready  = 1'b0;
    busy      = 1'b1;
    w_en      = 1'b0;
    w_addr    = in_cnt;
    x_hs      = 1'b0;
    y_hs      = y_tvalid & y_tready;
    case (state)
      IDLE: begin
        x_tready = 1'b1;
        busy     = 1'b0;
        if (x_tvalid) state_nxt = (in_cnt == LAST_IDX) ? BIAS : ACCUM;
      end
      ACCUM: begin
        x_tready = (in_cnt < BIAS_ROW);
        if (x_tvalid && x_tready && in_cnt == LAST_IDX) state_nxt = BIAS;
      end
      BIAS: begin
        w_en      = 1'b1;
        w_addr    = BIAS_ROW;
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (y_hs && y_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    x_hs = x_tvalid & x_tready;
    w_en = w_en | x_hs;
  end

  // Counters, pixel pipeline register and output valid.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      pix_q    <= '0;
      mac_v    <= 1'b0;
      first_q  <= 1'b0;
      bias_v   <= 1'b0;
      y_tvalid <= 1'b0;
    end else begin
      mac_v  <= x_hs;
      bias_v <= (state == BIAS);
      if (x_hs) begin
        pix_q   <= x_tdata[PIX_W-1:0];
        first_q <= (state == IDLE);
        in_cnt  <= in_cnt + ADDR_W'(1);
      end
      if (bias_v) y_tvalid <= 1'b1;
      if (y_hs) begin
        if (y_tlast) begin
          y_tvalid <= 1'b0;
          out_cnt  <= '0;
          in_cnt   <= '0;
        end else begin
          out_cnt <= out_cnt + OUT_W'(1);
        end
      end
    end
  end

  // Output word mux; activations are unsigned after ReLU so zero-extension is exact.
  always_comb begin
    y_tdata = 32'(act[out_cnt]);
    y_tlast = y_tvalid && (out_cnt == LAST_WORD);
  end

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
    mac_lane #(
      .PIX_W   (PIX_W),
      .WEIGHT_W(WEIGHT_W),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk     (s_axi_aclk),
      .rst_n   (s_axi_aresetn),
      .load    (mac_v & first_q),
      .accum   (mac_v & ~first_q),
      .bias_add(bias_v),
      .pix     (pix_q),
      .weight  (w_rdata[k*WEIGHT_W +: WEIGHT_W]),
      .act     (act[k])
    );
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Scoreboard bench for dense_layer_mac: a 32-bit and a 16-bit accumulator instance run in lockstep.
module tb_dense_layer_mac;

  localparam int unsigned NI = 4;
  localparam int unsigned NN = 2;
  localparam int unsigned AW = 3;
  localparam int unsigned WW = 8;

  logic              s_axi_aclk = 1'b0;
  logic              s_axi_aresetn = 1'b0;
  logic [31:0]       x_tdata = '0;
  logic              x_tvalid = 1'b0;
  logic              y_tready = 1'b1;
  logic [NN*WW-1:0]  w_rdata = '0;

  logic              x_tready, w_en, y_tvalid, y_tlast, busy;
  logic [AW-1:0]     w_addr;
  logic [31:0]       y_tdata;
  logic              x_tready16, w_en16, y_tvalid16, y_tlast16, busy16;
  logic [AW-1:0]     w_addr16;
  logic [31:0]       y_tdata16;

  logic [NN*WW-1:0]  wmem [NI+1];
  int                wts [NN][NI+1];
  int                img [NI];

  logic [31:0]       q32 [$];
  logic [31:0]       q16 [$];
  logic              qlast [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int stall_left = 0;
  logic prev_stall = 1'b0;
  logic prev_valid = 1'b0;
  logic [31:0] held = '0;

  dense_layer_mac #(
    .N_INPUTS(NI), .NUM_NEURONS(NN), .PIX_W(8), .WEIGHT_W(WW), .ACC_W(32), .ADDR_W(AW)
  ) dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
    .w_en(w_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tready(y_tready), .y_tlast(y_tlast),
    .busy(busy)
  );

  dense_layer_mac #(
    .N_INPUTS(NI), .NUM_NEURONS(NN), .PIX_W(8), .WEIGHT_W(WW), .ACC_W(16), .ADDR_W(AW)
  ) dut16 (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready16),
    .w_en(w_en16), .w_addr(w_addr16), .w_rdata(w_rdata),
    .y_tdata(y_tdata16), .y_tvalid(y_tvalid16), .y_tready(y_tready), .y_tlast(y_tlast16),
    .busy(busy16)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  // Weight BRAM model with one cycle read latency, plus a cycle counter.
  always @(posedge s_axi_aclk) begin
    cyc = cyc + 1;
    if (w_en) w_rdata <= wmem[w_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_weights(input int w0, input int b0, input int w1, input int b1);
    for (int i = 0; i < NI; i++) begin
      wts[0][i] = w0;
      wts[1][i] = w1;
      wmem[i]   = {8'(w1), 8'(w0)};
    end
    wts[0][NI] = b0;
    wts[1][NI] = b1;
    wmem[NI]   = {8'(b1), 8'(b0)};
  endtask

  task automatic set_img(input int p0, input int p1, input int p2, input int p3);
    img[0] = p0; img[1] = p1; img[2] = p2; img[3] = p3;
  endtask

  task automatic push_expected();
    int sum;
    logic signed [15:0] s16;
    for (int k = 0; k < NN; k++) begin
      sum = wts[k][NI];
      for (int i = 0; i < NI; i++) sum += img[i] * wts[k][i];
      s16 = 16'(sum);
      q32.push_back((sum < 0) ? 32'd0 : 32'(sum));
      q16.push_back((s16 < 0) ? 32'd0 : {16'd0, s16});
      qlast.push_back(k == NN - 1);
    end
  endtask

  task automatic send_pixel(input int p, input int idx);
    int n = 0;
    x_tdata  = {24'($urandom), 8'(p)};
    x_tvalid = 1'b1;
    #1;
    while (!(x_tready && x_tready16) && n < 200) begin
      @(negedge s_axi_aclk);
      #1;
      n++;
    end
    if (n >= 200) check_eq("x_ready_timeout", 32'(n), 0);
    if (n > 0) check_eq("stall_until_tlast", 32'(q32.size()), 0);
    check_eq("w_en_hs", 32'(w_en), 1);
    check_eq("w_addr", 32'(w_addr), 32'(idx));
    hs_cyc = cyc;
    @(negedge s_axi_aclk);
    x_tvalid = 1'b0;
  endtask

  task automatic run_image(input bit gap);
    for (int i = 0; i < NI; i++) begin
      send_pixel(img[i], i);
      if (gap && i < NI - 1) begin
        #1;
        check_eq("w_en_gap", 32'(w_en), 0);
        @(negedge s_axi_aclk);
      end
    end
    push_expected();
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q32.size() != 0 || busy) && n < 300) begin
      @(negedge s_axi_aclk);
      n++;
    end
    if (n >= 300) check_eq("drain_timeout", 32'(n), 0);
  endtask

  // Output monitor: drives y_tready backpressure and checks words against the scoreboard.
  always @(negedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (stall_left > 0 && y_tvalid) begin
        y_tready = 1'b0;
        stall_left--;
      end else begin
        y_tready = 1'b1;
      end
      if (prev_stall) begin
        check_eq("hold_data", y_tdata, held);
        check_eq("hold_valid", 32'(y_tvalid), 1);
      end
      if (y_tvalid && !prev_valid) check_eq("latency", 32'(cyc - hs_cyc), 3);
      if (y_tvalid) check_eq("x_ready_in_output", 32'(x_tready), 0);
      if (y_tvalid && y_tready) begin
        if (q32.size() == 0) begin
          check_eq("spurious_word", 32'(q32.size()), 1);
        end else begin
          check_eq("y_data", y_tdata, q32.pop_front());
          check_eq("y16_data", y_tdata16, q16.pop_front());
          check_eq("y_last", 32'(y_tlast), 32'(qlast[0]));
          check_eq("y16_last", 32'(y_tlast16), 32'(qlast.pop_front()));
        end
      end
      prev_stall = y_tvalid && !y_tready;
      held       = y_tdata;
      prev_valid = y_tvalid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_weights(1, 5, -1, 3);
    set_img(1, 2, 3, 4);
    repeat (2) @(negedge s_axi_aclk);
    check_eq("rst_x_tready", 32'(x_tready), 1);
    check_eq("rst_w_en", 32'(w_en), 0);
    check_eq("rst_w_addr", 32'(w_addr), 0);
    check_eq("rst_y_tvalid", 32'(y_tvalid), 0);
    check_eq("rst_y_tlast", 32'(y_tlast), 0);
    check_eq("rst_y_tdata", y_tdata, 0);
    check_eq("rst_busy", 32'(busy), 0);
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);

    // Basic image: 15 then 0.
    run_image(1'b0);
    wait_done();

    // Backpressure on word 0 for 5 cycles.
    stall_left = 5;
    run_image(1'b0);
    wait_done();

    // Gapped pixel stream.
    run_image(1'b1);
    wait_done();

    // Second image offered while the first is still being output.
    stall_left = 3;
    run_image(1'b0);
    @(negedge s_axi_aclk);
    set_weights(127, 0, -1, 3);
    set_img(255, 255, 255, 255);
    run_image(1'b0);
    wait_done();

    // Abort after two pixels, then a clean image.
    set_weights(1, 5, -1, 3);
    set_img(1, 2, 3, 4);
    send_pixel(9, 0);
    send_pixel(9, 1);
    s_axi_aresetn = 1'b0;
    repeat (2) @(negedge s_axi_aclk);
    check_eq("abort_x_tready", 32'(x_tready), 1);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_y_tvalid", 32'(y_tvalid), 0);
    check_eq("abort_w_en", 32'(w_en), 0);
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);
    run_image(1'b0);
    wait_done();

    repeat (3) @(negedge s_axi_aclk);
    check_eq("final_queue_empty", 32'(q32.size()), 0);
    check_eq("final_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
